// File: rtl/fixp_first_bit_normalizer_pkg.sv
// Shared widths, field offsets and the packed output beat layout of the first-bit normalizer.
package first_bit_checker_pkg;

    localparam int unsigned DATA_WIDTH = 192;

    // Number of bits needed to represent value.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((value >> i) != 0) result = i + 1;
        end
        return result;
    endfunction

    localparam int unsigned SHIFT_WIDTH = clogb2(DATA_WIDTH - 1);
    localparam int unsigned OUT_WIDTH   = DATA_WIDTH + SHIFT_WIDTH + 1;

    localparam int unsigned NZERO_BIT = 0;
    localparam int unsigned SHIFT_LSB = 1;
    localparam int unsigned DATA_LSB  = SHIFT_WIDTH + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  shift_data;
        logic [SHIFT_WIDTH-1:0] shift_info;
        logic                   nzero;
    } fbc_out_t;

endpackage

// File: rtl/fixp_first_bit_normalizer_leading_zero_count.sv
// Combinational leading-zero counter built as a binary tree priority encoder.
module leading_zero_count #(
    parameter int unsigned  DATA_WIDTH  = first_bit_checker_pkg::DATA_WIDTH,
    localparam int unsigned SHIFT_WIDTH = first_bit_checker_pkg::clogb2(DATA_WIDTH - 1)
) (
    input  logic [DATA_WIDTH-1:0]  data,
    output logic [SHIFT_WIDTH-1:0] count,
    output logic                   nzero
);

    localparam int unsigned Leaves = 1 << SHIFT_WIDTH;

    logic [Leaves-1:0]      pad;
    logic                   vld [SHIFT_WIDTH+1][Leaves];
    logic [SHIFT_WIDTH-1:0] cnt [SHIFT_WIDTH+1][Leaves];

    // Node i of level l covers 2**l leaves; leaf 0 is the MSB. A node whose left half is
    // empty adds that half's size (bit l) to the right half's count.
    always_comb begin
        pad = '0;
        pad[Leaves-1 -: DATA_WIDTH] = data;
        for (int l = 0; l <= SHIFT_WIDTH; l++) begin
            for (int i = 0; i < Leaves; i++) begin
                vld[l][i] = 1'b0;
                cnt[l][i] = '0;
            end
        end
        for (int i = 0; i < Leaves; i++) begin
            vld[0][i] = pad[Leaves-1-i];
        end
        for (int l = 0; l < SHIFT_WIDTH; l++) begin
            for (int i = 0; i < (Leaves >> (l + 1)); i++) begin
                vld[l+1][i] = vld[l][2*i] | vld[l][2*i+1];
                cnt[l+1][i] = vld[l][2*i] ? cnt[l][2*i]
                                          : (cnt[l][2*i+1] | SHIFT_WIDTH'(1 << l));
            end
        end
    end

    assign nzero = vld[SHIFT_WIDTH][0];
    assign count = nzero ? cnt[SHIFT_WIDTH][0] : '0;

endmodule

// File: rtl/fixp_first_bit_normalizer.sv
// Leading-one normalizer on a valid/ready stream: stage 1 counts leading zeros, stage 2 shifts.
// Defining FIRST_BIT_CHECKER_OUT_REG_EN adds a third, output register stage.
module fixp_first_bit_normalizer #(
    parameter int unsigned  DATA_WIDTH  = first_bit_checker_pkg::DATA_WIDTH,
    localparam int unsigned SHIFT_WIDTH = first_bit_checker_pkg::clogb2(DATA_WIDTH - 1),
    localparam int unsigned OUT_WIDTH   = DATA_WIDTH + SHIFT_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [OUT_WIDTH-1:0]  m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready
);

    logic [SHIFT_WIDTH-1:0] lzc_count;
    logic                   lzc_nzero;

    leading_zero_count #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lzc (
        .data  (s_tdata),
        .count (lzc_count),
        .nzero (lzc_nzero)
    );

    logic                   s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]  s1_data_q, s1_data_d;
    logic [SHIFT_WIDTH-1:0] s1_cnt_q, s1_cnt_d;
    logic                   s1_nz_q, s1_nz_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0]   s2_tdata_q, s2_tdata_d;
    logic                   s2_ready, s2_down_ready;
    logic [DATA_WIDTH-1:0]  shift_data;

    assign shift_data = s1_data_q << s1_cnt_q;
    assign s2_ready   = ~s2_valid_q | s2_down_ready;
    assign s_tready   = ~s1_valid_q | s2_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_cnt_d   = s1_cnt_q;
        s1_nz_d    = s1_nz_q;
        s2_valid_d = s2_valid_q;
        s2_tdata_d = s2_tdata_q;
        if (s_tready) begin
            s1_valid_d = s_tvalid;
            if (s_tvalid) begin
                s1_data_d = s_tdata;
                s1_cnt_d  = lzc_count;
                s1_nz_d   = lzc_nzero;
            end
        end
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) s2_tdata_d = {shift_data, s1_cnt_q, s1_nz_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_cnt_q   <= '0;
            s1_nz_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_tdata_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_nz_q    <= s1_nz_d;
            s2_valid_q <= s2_valid_d;
            s2_tdata_q <= s2_tdata_d;
        end
    end

`ifdef FIRST_BIT_CHECKER_OUT_REG_EN
    logic                 s3_valid_q, s3_valid_d;
    logic [OUT_WIDTH-1:0] s3_tdata_q, s3_tdata_d;
    logic                 s3_ready;

    assign s3_ready      = ~s3_valid_q | m_tready;
    assign s2_down_ready = s3_ready;

    always_comb begin
        s3_valid_d = s3_valid_q;
        s3_tdata_d = s3_tdata_q;
        if (s3_ready) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) s3_tdata_d = s2_tdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            s3_tdata_q <= '0;
        end else begin
            s3_valid_q <= s3_valid_d;
            s3_tdata_q <= s3_tdata_d;
        end
    end

    assign m_tvalid = s3_valid_q;
    assign m_tdata  = s3_tdata_q;
`else
    assign s2_down_ready = m_tready;
    assign m_tvalid      = s2_valid_q;
    assign m_tdata       = s2_tdata_q;
`endif

endmodule

// File: tb/tb_fixp_first_bit_normalizer.sv
// Randomized self-checking bench for fixp_first_bit_normalizer against a loop-based reference model.
module tb_fixp_first_bit_normalizer;
    import first_bit_checker_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int OW = OUT_WIDTH;
`ifdef FIRST_BIT_CHECKER_OUT_REG_EN
    localparam int Latency = 3;
`else
    localparam int Latency = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [OW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;

    fixp_first_bit_normalizer dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] word;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   prev_stall = 1'b0;
    bit   check_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scan from the MSB for the first one; shift it to the top.
    function automatic logic [255:0] ref_model(input logic [DW-1:0] d);
        fbc_out_t r;
        int       lz = -1;
        r = '0;
        for (int k = DW - 1; k >= 0; k--) begin
            if (d[k] && lz < 0) lz = DW - 1 - k;
        end
        if (lz >= 0) begin
            r.nzero      = 1'b1;
            r.shift_info = SHIFT_WIDTH'(lz);
            r.shift_data = d << lz;
        end
        return 256'(r);
    endfunction

    // Called at a negedge: drive inputs, check outputs, predict transfers at the next posedge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit rdy);
        s_tvalid = v;
        s_tdata  = d;
        m_tready = rdy;
        #1;
        if (prev_stall) check("stall_hold_valid", 256'(m_tvalid), 256'(1));
        if (exp_q.size() == 0) check("idle_valid", 256'(m_tvalid), 256'(0));
        if (m_tvalid) begin
            if (exp_q.size() == 0) check("spurious_beat", 256'(m_tvalid), 256'(0));
            else check("m_tdata", 256'(m_tdata), exp_q[0].word);
        end
        if (exp_q.size() >= Latency && !rdy) check("s_tready_full", 256'(s_tready), 256'(0));
        if (m_tvalid && m_tready && exp_q.size() > 0) begin
            if (check_lat) check("latency", 256'(cyc - exp_q[0].acc), 256'(Latency));
            void'(exp_q.pop_front());
        end
        if (s_tvalid && s_tready) exp_q.push_back('{word: ref_model(d), acc: cyc});
        prev_stall = m_tvalid && !m_tready;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            step(1'b0, '0, 1'b1);
            budget--;
        end
        check("drain_empty", 256'(exp_q.size()), 256'(0));
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        case ($urandom_range(0, 7))
            0:       w = '0;
            1, 2, 3: w = w >> $urandom_range(0, DW - 1);
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] one;
        one = 1;
        #2;
        check("rst_m_tvalid", 256'(m_tvalid), 256'(0));
        check("rst_m_tdata", 256'(m_tdata), 256'(0));
        check("rst_s_tready", 256'(s_tready), 256'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back walking one with latency tracking.
        check_lat = 1'b1;
        for (int k = 0; k < DW; k++) step(1'b1, one << k, 1'b1);
        drain();

        // Zero word, bits 2 and 0, and gaps between beats.
        step(1'b1, '0, 1'b1);
        step(1'b0, '1, 1'b1);
        step(1'b1, DW'(5), 1'b1);
        drain();
        check_lat = 1'b0;

        // Random data, random valid and ready.
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 9) < 7), rand_word(), $urandom_range(0, 1) == 1);
        end
        drain();

        // Fill the pipeline while stalled, then reset asynchronously mid-cycle.
        for (int n = 0; n < Latency + 1; n++) step(1'b1, rand_word(), 1'b0);
        check("held_beats", 256'(exp_q.size()), 256'(Latency));
        s_tvalid = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_rst_valid", 256'(m_tvalid), 256'(0));
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_lat = 1'b1;
        step(1'b1, one << (DW - 1), 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fixp_first_bit_normalizer.md
Name: fixp_first_bit_normalizer

Overview:
- Leading-one detector and normalizer for wide fixed-point words on an AXI-Stream-style valid/ready stream.
- For each input word it finds the most-significant set bit and shifts the word left so that bit lands at the MSB.
- It emits the shifted word, the shift amount and a non-zero flag as one packed output beat.
- Sits ahead of fixed-to-float/normalization logic in the datapath.

Parameters:
- DATA_WIDTH, 192, input word width (≥2).
- SHIFT_WIDTH, clogb2(DATA_WIDTH-1) = 8 for 192; derived localparam, not overridable. clogb2(x) is the number of bits needed to represent x.
- OUT_WIDTH, DATA_WIDTH+SHIFT_WIDTH+1 = 201; derived localparam.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_tdata  in  DATA_WIDTH  input word (fixp_in_stream.tdata).
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  block can accept an input beat.
- m_tdata  out  OUT_WIDTH  packed result (fixp_out_stream.tdata):
  - bit 0 = nzero;
  - bits [SHIFT_WIDTH:1] = shift_info;
  - bits [OUT_WIDTH-1:SHIFT_WIDTH+1] = shift_data.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream accepts the beat.

Interface note (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the system): all pipeline valid flags clear; m_tvalid=0 and m_tdata=0. s_tready=1 is permitted during and immediately after reset. Reset mid-operation drops all in-flight beats.
- Function, for input word D:
  - nzero = |D.
  - shift_info = number of leading zeros of D, counted from bit DATA_WIDTH-1; range 0..DATA_WIDTH-1.
  - shift_data = D << shift_info (zero-filled), truncated to DATA_WIDTH, so shift_data[DATA_WIDTH-1]=1 whenever nzero=1.
  - D==0 gives nzero=0, shift_info=0, shift_data=0.
- Pipeline: 2 register stages, latency 2 cycles at full throughput.
  - Stage 1 registers D, nzero and the leading-zero count.
  - Stage 2 registers the barrel-shift result and the packed output.
- Handshake:
  - Input transfer occurs on s_tvalid&&s_tready; output transfer on m_tvalid&&m_tready.
  - The pipeline advances when the stage ahead is empty or being drained (per-stage valid with ready = ~valid_next | ready_next).
  - s_tready = ~stage1_valid | stage1_advances.
  - 1 beat/cycle is sustained when m_tready=1.
  - With m_tready=0, at most 2 beats are held. s_tready falls no later than the cycle both stages are full. No beat is lost or duplicated.
- Stability: m_tdata and m_tvalid hold steady while m_tvalid=1 and m_tready=0.
- Simultaneous accept and drain in the same cycle keeps occupancy unchanged.
- s_tdata is ignored when s_tvalid=0. Beat order is preserved.

Optional Feature:
- Macro FIRST_BIT_CHECKER_OUT_REG_EN.
- Defined: adds a third pipeline stage (extra output register with the same valid/ready rule) for timing closure. Latency becomes 3 and up to 3 beats are buffered.
- Undefined: 2-stage pipeline as described above.
- Function and packing are identical in both builds.

Decomposition:
- Package first_bit_checker_pkg:
  - DATA_WIDTH default;
  - clogb2 function;
  - SHIFT_WIDTH and OUT_WIDTH;
  - field offsets NZERO_BIT=0, SHIFT_LSB=1, DATA_LSB=SHIFT_WIDTH+1;
  - a packed struct typedef {shift_data, shift_info, nzero}.
- One sub-module: leading_zero_count. Purely combinational, parameterized DATA_WIDTH; outputs count[SHIFT_WIDTH-1:0] and nzero; implemented as a tree priority encoder.
- The top holds the pipeline registers, handshake and barrel shifter.

Test Plan:
- Walking one, s_tdata=1<<k for k=0..191 back-to-back, m_tready=1. Each output has nzero=1, shift_info=191-k and shift_data=1<<191; outputs arrive in order, 2 cycles after acceptance.
- s_tdata=0 -> nzero=0, shift_info=0, shift_data=0.
- s_tdata=192'h5 (bits 2 and 0) -> shift_info=189, shift_data = 5<<189, i.e. bits 191 and 189 set.
- Random words with m_tready toggled randomly (~50%) -> scoreboard matches the reference model exactly; no drop or duplicate; m_tdata stable while stalled; s_tready=0 once 2 beats are held.
- Assert rst with 2 beats in flight -> m_tvalid=0 immediately (asynchronous); after release the first new input 1<<191 yields shift_info=0, nzero=1.
- Build with FIRST_BIT_CHECKER_OUT_REG_EN -> walking-one results identical, latency 3 cycles.
